// File: rtl/uart_rx_fifo.sv
// Oversampled UART receiver feeding a show-ahead receive FIFO; word visible one cycle after the stop-bit push.
// Backpressure: consumer holds rx_ready low to stall; a good frame arriving on a full FIFO is dropped with overrun.

module uart_rx_fifo_buf #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk_in,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic [W-1:0]               wr_dat_i,
  input  logic                       pop_i,
  output logic [W-1:0]               rd_dat_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic [$clog2(DEPTH):0]     count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      // On a full FIFO a same-cycle pop frees the head slot, which is also the write slot.
      if (push_i) begin
        mem_q[wr_ptr_q] <= wr_dat_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop_i) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign rd_dat_o = mem_q[rd_ptr_q];
  assign empty_o  = (count_q == '0);
  assign full_o   = (count_q == (AW+1)'(DEPTH));
  assign count_o  = count_q;
endmodule

module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 64,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                            clk_in,
  input  logic                            reset,
  input  logic                            rx_fem,
  output logic [DATA_BITS-1:0]            rx_data,
  output logic                            rx_valid,
  input  logic                            rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
  output logic                            parity_err,
  output logic                            framing_err,
  output logic                            overrun
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] MID  = CW'(CLKS_PER_BIT/2 - 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_BREAK
  } state_t;

  state_t               state_q, state_d;
  logic                 sync1_q, rxs_q;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 par_q, par_d;
  logic                 stop_bad_q, stop_bad_d;

  logic mid, frame_done, bad_par, bad_stop, par_fail;
  logic frame_ok, pop, push, full, empty;

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      sync1_q    <= 1'b1;
      rxs_q      <= 1'b1;
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shreg_q    <= '0;
      par_q      <= 1'b0;
      stop_bad_q <= 1'b0;
    end else begin
      sync1_q    <= rx_fem;
      rxs_q      <= sync1_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      par_q      <= par_d;
      stop_bad_q <= stop_bad_d;
    end
  end

  assign mid = (cnt_q == MID);

  always_comb begin
    if (PARITY_MODE == 1)      par_fail = ^shreg_q ^ par_q;
    else if (PARITY_MODE == 2) par_fail = ~(^shreg_q ^ par_q);
    else                       par_fail = 1'b0;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    bit_d      = bit_q;
    shreg_d    = shreg_q;
    par_d      = par_q;
    stop_bad_d = stop_bad_q;
    frame_done = 1'b0;
    bad_par    = 1'b0;
    bad_stop   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!rxs_q) state_d = ST_START;
      end
      ST_START: begin
        if (mid) begin
          if (rxs_q) state_d = ST_IDLE;
          else begin
            state_d = ST_DATA;
            bit_d   = '0;
          end
        end
      end
      ST_DATA: begin
        if (mid) begin
          shreg_d = {rxs_q, shreg_q[DATA_BITS-1:1]};
          if (bit_q == 4'(DATA_BITS - 1)) begin
            bit_d      = '0;
            stop_bad_d = 1'b0;
            state_d    = (PARITY_MODE != 0) ? ST_PARITY : ST_STOP;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      ST_PARITY: begin
        if (mid) begin
          par_d   = rxs_q;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (mid) begin
          stop_bad_d = stop_bad_q | ~rxs_q;
          if (bit_q == 4'(STOP_BITS - 1)) begin
            frame_done = 1'b1;
            bad_stop   = stop_bad_q | ~rxs_q;
            bad_par    = par_fail;
            state_d    = bad_stop ? ST_BREAK : ST_IDLE;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      ST_BREAK: begin
        // A line held low stays here so it reports only one framing error.
        cnt_d = '0;
        if (rxs_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign frame_ok    = frame_done & ~bad_stop & ~bad_par;
  assign pop         = rx_valid & rx_ready;
  assign push        = frame_ok & (~full | pop);
  assign overrun     = frame_ok & full & ~pop;
  assign parity_err  = bad_par;
  assign framing_err = bad_stop;
  assign rx_valid    = ~empty;

  uart_rx_fifo_buf #(
    .W     (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_buf (
    .clk_in   (clk_in),
    .reset    (reset),
    .push_i   (push),
    .wr_dat_i (shreg_q),
    .pop_i    (pop),
    .rd_dat_o (rx_data),
    .empty_o  (empty),
    .full_o   (full),
    .count_o  (fifo_count)
  );
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench: directed frames push expected words; negedge monitors pop and compare.
module tb_uart_rx_fifo;
  localparam int CPB = 64;

  logic clk_in = 1'b0;
  always #10 clk_in = ~clk_in;

  logic       reset, rx0, rxp, rdy0;
  logic       rdyp = 1'b1;
  logic [7:0] d0, d1, d2;
  logic       v0, v1, v2;
  logic [2:0] c0, c1, c2;
  logic       pe0, fe0, ov0, pe1, fe1, ov1, pe2, fe2, ov2;

  uart_rx_fifo u0 (.clk_in(clk_in), .reset(reset), .rx_fem(rx0), .rx_data(d0), .rx_valid(v0),
                   .rx_ready(rdy0), .fifo_count(c0), .parity_err(pe0), .framing_err(fe0), .overrun(ov0));
  uart_rx_fifo #(.PARITY_MODE(1)) u1 (.clk_in(clk_in), .reset(reset), .rx_fem(rxp), .rx_data(d1),
                   .rx_valid(v1), .rx_ready(rdyp), .fifo_count(c1), .parity_err(pe1),
                   .framing_err(fe1), .overrun(ov1));
  uart_rx_fifo #(.PARITY_MODE(2)) u2 (.clk_in(clk_in), .reset(reset), .rx_fem(rxp), .rx_data(d2),
                   .rx_valid(v2), .rx_ready(rdyp), .fifo_count(c2), .parity_err(pe2),
                   .framing_err(fe2), .overrun(ov2));

  logic [7:0] q0[$], q1[$], q2[$];
  int vectors = 0, miscompares = 0;
  int pe0_n = 0, fe0_n = 0, ov0_n = 0, pe1_n = 0, fe1_n = 0, pe2_n = 0, fe2_n = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic empty_pop(input string nm, input logic [7:0] act);
    vectors++;
    miscompares++;
    $display("FAIL %s: popped %0h with no word expected at %0t", nm, act, $time);
  endtask

  always @(negedge clk_in) begin
    pe0_n += 32'(pe0); fe0_n += 32'(fe0); ov0_n += 32'(ov0);
    pe1_n += 32'(pe1); fe1_n += 32'(fe1);
    pe2_n += 32'(pe2); fe2_n += 32'(fe2);
    if (!reset) begin
      if (v0 && rdy0) begin
        if (q0.size() == 0) empty_pop("u0_pop", d0);
        else chk("u0_data", 32'(d0), 32'(q0.pop_front()));
      end
      if (v1) begin
        if (q1.size() == 0) empty_pop("u1_pop", d1);
        else chk("u1_data", 32'(d1), 32'(q1.pop_front()));
      end
      if (v2) begin
        if (q2.size() == 0) empty_pop("u2_pop", d2);
        else chk("u2_data", 32'(d2), 32'(q2.pop_front()));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic tx0_head(input logic [7:0] d);
    rx0 = 1'b0;
    cyc(CPB);
    for (int i = 0; i < 8; i++) begin
      rx0 = d[i];
      cyc(CPB);
    end
  endtask

  task automatic tx0(input logic [7:0] d, input logic stopv);
    tx0_head(d);
    rx0 = stopv;
    cyc(CPB);
    rx0 = 1'b1;
    cyc(4);
  endtask

  task automatic txp(input logic [7:0] d, input logic p);
    rxp = 1'b0;
    cyc(CPB);
    for (int i = 0; i < 8; i++) begin
      rxp = d[i];
      cyc(CPB);
    end
    rxp = p;
    cyc(CPB);
    rxp = 1'b1;
    cyc(CPB + 4);
  endtask

  int base;

  initial begin
    reset = 1'b1; rx0 = 1'b1; rxp = 1'b1; rdy0 = 1'b0;
    cyc(3);
    chk("rst_valid", 32'(v0), 32'd0);
    chk("rst_count", 32'(c0), 32'd0);
    chk("rst_data",  32'(d0), 32'd0);
    chk("rst_errs",  32'({pe0, fe0, ov0}), 32'd0);
    reset = 1'b0;
    cyc(5);

    // Basic 8N1 frame 0x55, held in the FIFO then popped
    q0.push_back(8'h55);
    tx0(8'h55, 1'b1);
    chk("f55_valid", 32'(v0), 32'd1);
    chk("f55_count", 32'(c0), 32'd1);
    chk("f55_head",  32'(d0), 32'h55);
    chk("f55_errs",  32'(pe0_n + fe0_n + ov0_n), 32'd0);
    rdy0 = 1'b1;
    cyc(3);
    chk("f55_drained", 32'(v0), 32'd0);

    // Start-bit glitch shorter than half a bit
    rx0 = 1'b0; cyc(20); rx0 = 1'b1; cyc(100);
    chk("glitch_valid", 32'(v0), 32'd0);
    chk("glitch_errs",  32'(pe0_n + fe0_n + ov0_n), 32'd0);

    // Bad stop bit followed by a long break, then a clean frame
    base = fe0_n;
    tx0_head(8'h3C);
    rx0 = 1'b0; cyc(CPB + 300);
    rx0 = 1'b1; cyc(10);
    chk("break_fe_once", 32'(fe0_n - base), 32'd1);
    chk("break_count",   32'(c0), 32'd0);
    q0.push_back(8'h11);
    tx0(8'h11, 1'b1);
    cyc(5);
    chk("after_break_q", 32'(q0.size()), 32'd0);

    // 0xA3 has four ones: p=0 is good even / bad odd, p=1 the reverse
    q1.push_back(8'hA3);
    txp(8'hA3, 1'b0);
    chk("par0_odd_err",  32'(pe2_n), 32'd1);
    chk("par0_odd_cnt",  32'(c2), 32'd0);
    chk("par0_even_ok",  32'(pe1_n), 32'd0);
    q2.push_back(8'hA3);
    txp(8'hA3, 1'b1);
    chk("par1_even_err", 32'(pe1_n), 32'd1);
    chk("par1_odd_ok",   32'(pe2_n), 32'd1);
    chk("par_queues",    32'(q1.size() + q2.size()), 32'd0);
    chk("par_no_fe",     32'(fe1_n + fe2_n), 32'd0);

    // Overrun: five frames into a four-entry FIFO
    rdy0 = 1'b0;
    base = ov0_n;
    for (int d = 1; d <= 5; d++) begin
      if (d <= 4) q0.push_back(8'(d));
      tx0(8'(d), 1'b1);
    end
    chk("ovr_count", 32'(c0), 32'd4);
    chk("ovr_pulse", 32'(ov0_n - base), 32'd1);
    chk("ovr_head",  32'(d0), 32'h01);
    rdy0 = 1'b1;
    cyc(10);
    chk("ovr_drained", 32'(v0), 32'd0);
    chk("ovr_q",       32'(q0.size()), 32'd0);

    // Full FIFO with a pop exactly on the push cycle of 0xEE
    rdy0 = 1'b0;
    for (int d = 0; d < 4; d++) begin
      q0.push_back(8'hA1 + 8'(d));
      tx0(8'hA1 + 8'(d), 1'b1);
    end
    base = ov0_n;
    q0.push_back(8'hEE);
    tx0_head(8'hEE);
    rx0 = 1'b1;
    cyc(CPB/2 + 2);
    rdy0 = 1'b1;
    cyc(1);
    rdy0 = 1'b0;
    cyc(CPB/2 - 3 + 4);
    chk("simul_count", 32'(c0), 32'd4);
    chk("simul_no_ovr", 32'(ov0_n - base), 32'd0);
    rdy0 = 1'b1;
    cyc(10);
    chk("simul_q", 32'(q0.size()), 32'd0);
    chk("simul_drained", 32'(v0), 32'd0);

    // Reset mid-frame with a word stored
    rdy0 = 1'b0;
    tx0(8'h77, 1'b1);
    chk("pre_rst_count", 32'(c0), 32'd1);
    rx0 = 1'b0;
    cyc(200);
    reset = 1'b1;
    cyc(2);
    chk("midrst_valid", 32'(v0), 32'd0);
    chk("midrst_count", 32'(c0), 32'd0);
    q0.delete();
    rx0 = 1'b1;
    reset = 1'b0;
    cyc(20);
    rdy0 = 1'b1;
    q0.push_back(8'h42);
    tx0(8'h42, 1'b1);
    cyc(5);
    chk("post_rst_q", 32'(q0.size()), 32'd0);
    chk("post_rst_fe", 32'(fe0), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
